// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM write-port arbiter.
package vram_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 8;
   localparam int BURST_W    = 8;

   // Grant recorded for the previous cycle.
   typedef enum logic [1:0] {
      GS_IDLE = 2'd0,
      GS_ACC  = 2'd1,
      GS_CPU  = 2'd2
   } grant_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } wr_req_t;

endpackage

// File: rtl/vram_wr_prio_sel.sv
// Combinational grant selector: accelerator priority, CPU forced through
// once the accelerator has used up its burst allowance.
module vram_wr_prio_sel
   import vram_pkg::*;
(
   input  logic               acc_valid_i,
   input  logic               cpu_valid_i,
   input  logic [BURST_W-1:0] burst_cnt_i,
   input  logic [BURST_W-1:0] max_burst_i,
   output grant_e             grant_o,
   output logic               starved_o
);

   // Starvation override first, then accelerator, then CPU.
   always_comb begin
      starved_o = acc_valid_i && cpu_valid_i && (burst_cnt_i == max_burst_i);
      grant_o   = GS_IDLE;
      if (acc_valid_i && !starved_o) begin
         grant_o = GS_ACC;
      end else if (cpu_valid_i) begin
         grant_o = GS_CPU;
      end
   end

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM write-port arbiter between accelerator writeback and CPU loads.
// state | meaning
// IDLE  | no grant last cycle (vram_we low)
// ACC   | accelerator granted last cycle
// CPU   | CPU granted last cycle
module vram_write_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int MAX_ACC_BURST = 8,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              acc_valid,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic              acc_ready,
   input  logic              cpu_valid,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_wdata,
   output logic [CNT_W-1:0]  acc_wr_count,
   output logic [CNT_W-1:0]  cpu_wr_count,
   output logic              cpu_starved
);

   localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_ACC_BURST);

   grant_e              grant;
   grant_e              state_q;
   logic                starved;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    acc_cnt_q;
   logic [CNT_W-1:0]    cpu_cnt_q;
   logic [BURST_W-1:0]  burst_q;
   logic [BURST_W-1:0]  burst_d;

   vram_wr_prio_sel u_sel (
      .acc_valid_i (acc_valid),
      .cpu_valid_i (cpu_valid),
      .burst_cnt_i (burst_q),
      .max_burst_i (MAX_B),
      .grant_o     (grant),
      .starved_o   (starved)
   );

   // Ready is held low during reset so nothing is accepted while the port is dead.
   assign acc_ready   = resetn && (grant == GS_ACC);
   assign cpu_ready   = resetn && (grant == GS_CPU);
   assign cpu_starved = starved;

   // Burst allowance only runs while the CPU is actually waiting.
   always_comb begin
      burst_d = burst_q;
      if ((grant == GS_CPU) || !cpu_valid) begin
         burst_d = '0;
      end else if ((grant == GS_ACC) && (burst_q != MAX_B)) begin
         burst_d = burst_q + 1'b1;
      end
   end

   // Grant FSM, registered write port and statistics.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= GS_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         acc_cnt_q <= '0;
         cpu_cnt_q <= '0;
         burst_q   <= '0;
      end else begin
         state_q <= grant;
         burst_q <= burst_d;
         case (grant)
            GS_ACC: begin
               addr_q    <= acc_addr;
               wdata_q   <= acc_wdata;
               acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
            GS_CPU: begin
               addr_q    <= cpu_addr;
               wdata_q   <= cpu_wdata;
               cpu_cnt_q <= cpu_cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign vram_we      = (state_q != GS_IDLE);
   assign vram_addr    = addr_q;
   assign vram_wdata   = wdata_q;
   assign acc_wr_count = acc_cnt_q;
   assign cpu_wr_count = cpu_cnt_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized and directed bench for vram_write_arbiter with a transaction-level model.
module tb_vram_write_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 8;
   localparam int MAX    = 8;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              resetn;
   logic              acc_valid, cpu_valid;
   logic [ADDR_W-1:0] acc_addr, cpu_addr;
   logic [DATA_W-1:0] acc_wdata, cpu_wdata;
   logic              acc_ready, cpu_ready;
   logic              vram_we;
   logic [ADDR_W-1:0] vram_addr;
   logic [DATA_W-1:0] vram_wdata;
   logic [CNT_W-1:0]  acc_wr_count, cpu_wr_count;
   logic              cpu_starved;

   vram_write_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ACC_BURST(MAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .resetn(resetn),
      .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_ready(acc_ready),
      .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
      .acc_wr_count(acc_wr_count), .cpu_wr_count(cpu_wr_count), .cpu_starved(cpu_starved)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: accepted-write bookkeeping and the CPU's waiting history.
   int                m_acc_cnt, m_cpu_cnt;
   int                m_acc_run;
   bit                exp_we;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   bit                obs_acc_rdy, obs_cpu_rdy, obs_starved;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_acc_cnt = 0;
      m_cpu_cnt = 0;
      m_acc_run = 0;
      exp_we    = 0;
      exp_addr  = '0;
      exp_data  = '0;
   endtask

   // One clock cycle: check everything at the falling edge, advance the model, step.
   task automatic cycle();
      bit both, want_cpu, want_acc, starve;
      @(negedge clk);
      both     = acc_valid && cpu_valid;
      starve   = both && (m_acc_run >= MAX);
      want_cpu = cpu_valid && (!acc_valid || starve);
      want_acc = acc_valid && !want_cpu;
      obs_acc_rdy = acc_ready;
      obs_cpu_rdy = cpu_ready;
      obs_starved = cpu_starved;
      check("acc_ready", 32'(acc_ready), 32'(want_acc));
      check("cpu_ready", 32'(cpu_ready), 32'(want_cpu));
      check("cpu_starved", 32'(cpu_starved), 32'(starve));
      check("vram_we", 32'(vram_we), 32'(exp_we));
      if (exp_we) begin
         check("vram_addr", 32'(vram_addr), 32'(exp_addr));
         check("vram_wdata", 32'(vram_wdata), 32'(exp_data));
      end
      check("acc_wr_count", 32'(acc_wr_count), 32'(m_acc_cnt & 16'hFFFF));
      check("cpu_wr_count", 32'(cpu_wr_count), 32'(m_cpu_cnt & 16'hFFFF));
      exp_we = want_acc || want_cpu;
      if (want_acc) begin
         exp_addr = acc_addr; exp_data = acc_wdata; m_acc_cnt++;
         if (cpu_valid) m_acc_run++;
      end
      if (want_cpu) begin
         exp_addr = cpu_addr; exp_data = cpu_wdata; m_cpu_cnt++;
      end
      if (want_cpu || !cpu_valid) m_acc_run = 0;
      @(posedge clk);
      #1;
   endtask

   int base_acc, base_cpu, n_starve, n_acc_before;
   bit acc_pend, cpu_pend;

   initial begin
      resetn = 1'b0;
      acc_valid = 1'b1; acc_addr = 24'h000200; acc_wdata = 8'h5A;
      cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      model_reset();

      // Reset with accelerator already requesting.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst acc_ready", 32'(acc_ready), 32'd0);
      check("rst vram_we", 32'(vram_we), 32'd0);
      check("rst acc_cnt", 32'(acc_wr_count), 32'd0);
      check("rst cpu_cnt", 32'(cpu_wr_count), 32'd0);
      check("rst starved", 32'(cpu_starved), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;
      // Edge just taken accepted the held write; re-align the model to it.
      exp_we = 1; exp_addr = 24'h000200; exp_data = 8'h5A; m_acc_cnt = 1;
      acc_valid = 1'b0;
      cycle();

      // CPU alone.
      cpu_valid = 1'b1; cpu_addr = 24'h000010; cpu_wdata = 8'hAB;
      base_cpu = m_cpu_cnt;
      cycle();
      check("cpu alone ready", 32'(obs_cpu_rdy), 32'd1);
      cpu_valid = 1'b0;
      cycle();
      check("cpu alone count", 32'(cpu_wr_count), 32'(base_cpu + 1));

      // Both valid continuously: 8 ACC then 1 CPU.
      base_acc = m_acc_cnt; base_cpu = m_cpu_cnt; n_starve = 0;
      for (int i = 0; i < 18; i++) begin
         acc_valid = 1'b1; acc_addr = 24'(i); acc_wdata = 8'(i + 8'h40);
         cpu_valid = 1'b1; cpu_addr = 24'(i + 24'h800); cpu_wdata = 8'(i + 8'h80);
         cycle();
         if (obs_starved) n_starve++;
      end
      acc_valid = 1'b0; cpu_valid = 1'b0;
      cycle();
      check("burst acc count", 32'(acc_wr_count), 32'((base_acc + 16) & 16'hFFFF));
      check("burst cpu count", 32'(cpu_wr_count), 32'((base_cpu + 2) & 16'hFFFF));
      check("starve pulses", 32'(n_starve), 32'd2);

      // CPU withdraws after 3 ACC grants: allowance restarts from zero.
      acc_valid = 1'b1; cpu_valid = 1'b1;
      repeat (3) cycle();
      cpu_valid = 1'b0;
      cycle();
      cpu_valid = 1'b1;
      n_acc_before = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (obs_cpu_rdy) break;
         if (obs_acc_rdy) n_acc_before++;
      end
      check("acc grants before cpu", 32'(n_acc_before), 32'd8);
      acc_valid = 1'b0; cpu_valid = 1'b0;
      cycle();

      // Same address, grant order preserved.
      acc_valid = 1'b1; acc_addr = 24'h000100; acc_wdata = 8'h11;
      cpu_valid = 1'b1; cpu_addr = 24'h000100; cpu_wdata = 8'h22;
      repeat (9) cycle();
      check("same addr last grant", 32'(obs_cpu_rdy), 32'd1);
      acc_valid = 1'b0; cpu_valid = 1'b0;
      cycle();
      check("same addr final data", 32'(vram_wdata), 32'h22);

      // Randomized traffic; requesters hold until accepted.
      acc_pend = 0; cpu_pend = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!acc_pend && ($urandom_range(0, 9) < 7)) begin
            acc_pend = 1; acc_addr = 24'($urandom); acc_wdata = 8'($urandom);
         end
         if (!cpu_pend && ($urandom_range(0, 9) < 5)) begin
            cpu_pend = 1; cpu_addr = 24'($urandom); cpu_wdata = 8'($urandom);
         end
         acc_valid = acc_pend; cpu_valid = cpu_pend;
         cycle();
         if (obs_acc_rdy) acc_pend = 0;
         if (obs_cpu_rdy) cpu_pend = 0;
      end

      // Async reset with a write pending on the port.
      acc_valid = 1'b1; acc_addr = 24'h123456; acc_wdata = 8'h77; cpu_valid = 1'b0;
      cycle();
      #2;
      check("pre-reset vram_we", 32'(vram_we), 32'd1);
      resetn = 1'b0;
      #1;
      check("async vram_we", 32'(vram_we), 32'd0);
      check("async acc_cnt", 32'(acc_wr_count), 32'd0);
      check("async cpu_cnt", 32'(cpu_wr_count), 32'd0);
      check("async acc_ready", 32'(acc_ready), 32'd0);
      acc_valid = 1'b0;
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      cycle();
      acc_valid = 1'b1; cpu_valid = 1'b1;
      repeat (10) cycle();
      acc_valid = 1'b0; cpu_valid = 1'b0;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
